// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction-fetch port
// and the data port. The data port wins simultaneous requests. Each transfer is
// held until the RAM acknowledges or a timeout expires, and it completes with a
// one-cycle hit pulse on the granted port.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   iREN, iaddr           instruction read request / word address
//   iload, ihit           instruction read data / completion pulse
//   dREN, dWEN            data read / write request (both set means a write)
//   daddr, dstore         data word address / write value
//   dload, dhit           data read data / completion pulse
//   ramREN, ramWEN        RAM read / write strobes
//   ramaddr, ramstore     RAM address / write data
//   ramload               RAM read data
//   ram_ready, ram_error  RAM completion / error indication
//   busy                  an access is in flight (IACC, DACC or RESP)
//   err                   sticky: timeout or RAM error seen since reset
module mem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        ihit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dhit,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    input  logic        ram_error,
    output logic        busy,
    output logic        err
);

    typedef enum logic [1:0] {StIdle, StIacc, StDacc, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] iload_q, iload_d;
    logic [31:0] dload_q, dload_d;
    logic        is_data_q, is_data_d;   // granted port: 1 = data, 0 = instruction
    logic        is_write_q, is_write_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rd_value;

    assign iload = iload_q;
    assign dload = dload_q;
    assign err   = err_q;
    assign busy  = (state_q != StIdle);

    // Value captured on a read exit by ram_ready; an errored read yields ERR_WORD.
    assign rd_value = ram_error ? ERR_WORD : ramload;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        iload_d    = iload_q;
        dload_d    = dload_q;
        is_data_d  = is_data_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = 32'h0;
        ramstore   = 32'h0;
        ihit       = 1'b0;
        dhit       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (dREN || dWEN) begin
                    state_d    = StDacc;
                    is_data_d  = 1'b1;
                    is_write_d = dWEN;
                    addr_d     = daddr;
                    wdata_d    = dstore;
                end else if (iREN) begin
                    state_d    = StIacc;
                    is_data_d  = 1'b0;
                    is_write_d = 1'b0;
                    addr_d     = iaddr;
                    wdata_d    = 32'h0;
                end
            end
            StIacc, StDacc: begin
                ramREN   = ~is_write_q;
                ramWEN   = is_write_q;
                ramaddr  = addr_q;
                ramstore = wdata_q;
                cnt_d    = cnt_q + 8'd1;
                if (ram_ready) begin
                    state_d = StResp;
                    if (ram_error) begin
                        err_d = 1'b1;
                    end
                    if (!is_write_q) begin
                        if (is_data_q) begin
                            dload_d = rd_value;
                        end else begin
                            iload_d = rd_value;
                        end
                    end
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    // Hung RAM: reads return ERR_WORD, writes are dropped.
                    state_d = StResp;
                    err_d   = 1'b1;
                    if (!is_write_q) begin
                        if (is_data_q) begin
                            dload_d = ERR_WORD;
                        end else begin
                            iload_d = ERR_WORD;
                        end
                    end
                end
            end
            StResp: begin
                ihit    = ~is_data_q;
                dhit    = is_data_q;
                cnt_d   = 8'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            iload_q    <= 32'h0;
            dload_q    <= 32'h0;
            is_data_q  <= 1'b0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            iload_q    <= iload_d;
            dload_q    <= dload_d;
            is_data_q  <= is_data_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = 32'h0, daddr = 32'h0, dstore = 32'h0;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, busy, err;
    logic [31:0] ramload = 32'h0;
    logic        ram_ready = 1'b0, ram_error = 1'b0;

    int total = 0;
    int bad   = 0;

    // RAM responder setup: ready in the lat-th strobe cycle (0 = never).
    int          lat   = 0;
    logic [31:0] rdata = 32'h0;
    logic        rerr  = 1'b0;
    int          scnt  = 0;

    typedef struct {
        bit          is_data;
        bit          chk;
        logic [31:0] val;
    } hit_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          len;   // 0 = do not check length (aborted access)
    } acc_t;

    hit_t hq[$];
    acc_t aq[$];

    mem_arbiter #(.TIMEOUT(8), .ERR_WORD(32'hBAD1BAD1)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ram_ready(ram_ready), .ram_error(ram_error),
        .busy(busy), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // RAM model
    always @(posedge CLK) begin
        #1;
        if (ramREN || ramWEN) scnt++;
        else scnt = 0;
        if ((ramREN || ramWEN) && lat != 0 && scnt == lat) begin
            ram_ready = 1'b1;
            ram_error = rerr;
            ramload   = rdata;
        end else begin
            ram_ready = 1'b0;
            ram_error = 1'b0;
        end
    end

    // Monitor / scoreboard
    bit   prev_strobe = 0, prev_hit = 0, in_acc = 0;
    int   len = 0;
    acc_t cur;
    hit_t h;
    always @(negedge CLK) begin
        if (RST) begin
            in_acc = 0; prev_strobe = 0; prev_hit = 0;
        end else begin
            check("strobe_excl", 32'(ramREN & ramWEN), 0);
            if ((ramREN | ramWEN) && !prev_strobe) begin
                if (aq.size() == 0) check("acc_unexpected", 1, 0);
                else begin cur = aq.pop_front(); in_acc = 1; len = 0; end
            end
            if ((ramREN | ramWEN) && in_acc) begin
                len++;
                check("acc_wr", 32'(ramWEN), 32'(cur.wr));
                check("acc_addr", ramaddr, cur.addr);
                if (cur.wr) check("acc_data", ramstore, cur.data);
            end
            if (!(ramREN | ramWEN) && prev_strobe && in_acc) begin
                if (cur.len != 0) check("acc_len", len, cur.len);
                in_acc = 0;
            end
            if (ihit | dhit) begin
                check("hit_after_strobe", 32'(prev_strobe), 1);
                check("hit_both", 32'(ihit & dhit), 0);
                check("hit_busy", 32'(busy), 1);
                if (hq.size() == 0) check("hit_unexpected", 1, 0);
                else begin
                    h = hq.pop_front();
                    check("hit_port", 32'(dhit), 32'(h.is_data));
                    if (h.chk) check("hit_load", dhit ? dload : iload, h.val);
                end
            end
            if (prev_hit) check("idle_after_hit", 32'(busy), 0);
            prev_strobe = ramREN | ramWEN;
            prev_hit    = ihit | dhit;
        end
    end

    task automatic cyc();
        @(posedge CLK); #1;
    endtask

    task automatic wait_hit(input bit want_d);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge CLK);
            if (want_d ? dhit : ihit) seen = 1;
        end
        if (!seen) check("hit_timeout", 0, 1);
        cyc();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ramREN"}, 32'(ramREN), 0);
        check({tag, "_ramWEN"}, 32'(ramWEN), 0);
        check({tag, "_ramaddr"}, ramaddr, 0);
        check({tag, "_ramstore"}, ramstore, 0);
        check({tag, "_iload"}, iload, 0);
        check({tag, "_dload"}, dload, 0);
        check({tag, "_ihit"}, 32'(ihit), 0);
        check({tag, "_dhit"}, 32'(dhit), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        cyc(); cyc(); cyc();
        check_all_zero("reset");
        RST = 1'b0;
        cyc();

        // Instruction read, ready in 3rd strobe cycle
        lat = 3; rdata = 32'h2001000A; rerr = 0;
        aq.push_back('{wr: 0, addr: 32'h40, data: 32'h0, len: 3});
        hq.push_back('{is_data: 0, chk: 1, val: 32'h2001000A});
        iREN = 1; iaddr = 32'h40;
        cyc();
        check("ird_cycle1_ramREN", 32'(ramREN), 1);
        check("ird_cycle1_ramaddr", ramaddr, 32'h40);
        wait_hit(0);
        iREN = 0;
        cyc();

        // Simultaneous: data write first, then instruction read
        lat = 2; rdata = 32'h13;
        aq.push_back('{wr: 1, addr: 32'h100, data: 32'hDEADBEEF, len: 2});
        aq.push_back('{wr: 0, addr: 32'h44, data: 32'h0, len: 2});
        hq.push_back('{is_data: 1, chk: 0, val: 32'h0});
        hq.push_back('{is_data: 0, chk: 1, val: 32'h13});
        iREN = 1; iaddr = 32'h44; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        wait_hit(1);
        dWEN = 0;
        wait_hit(0);
        iREN = 0;
        cyc();

        // Data read with daddr/dstore changing mid-access
        lat = 4; rdata = 32'h55AA;
        aq.push_back('{wr: 0, addr: 32'h300, data: 32'h0, len: 4});
        hq.push_back('{is_data: 1, chk: 1, val: 32'h55AA});
        dREN = 1; daddr = 32'h300;
        cyc(); cyc();
        daddr = 32'h999; dstore = 32'h1;
        wait_hit(1);
        dREN = 0;
        cyc();
        check("iload_hold", iload, 32'h13);
        check("err_clean", 32'(err), 0);

        // Errored instruction read
        lat = 1; rdata = 32'h1234; rerr = 1;
        aq.push_back('{wr: 0, addr: 32'h80, data: 32'h0, len: 1});
        hq.push_back('{is_data: 0, chk: 1, val: 32'hBAD1BAD1});
        iREN = 1; iaddr = 32'h80;
        wait_hit(0);
        iREN = 0; rerr = 0;
        cyc();
        check("err_after_ram_error", 32'(err), 1);
        check("dload_hold", dload, 32'h55AA);

        // Reset in the middle of a data write
        lat = 0;
        aq.push_back('{wr: 1, addr: 32'h500, data: 32'h77, len: 0});
        dWEN = 1; daddr = 32'h500; dstore = 32'h77;
        cyc(); cyc();
        RST = 1; dWEN = 0;
        cyc();
        check_all_zero("midrst");
        RST = 0;
        cyc();

        // Timeout on a data read after the reset
        lat = 0;
        aq.push_back('{wr: 0, addr: 32'h200, data: 32'h0, len: 8});
        hq.push_back('{is_data: 1, chk: 1, val: 32'hBAD1BAD1});
        dREN = 1; daddr = 32'h200;
        wait_hit(1);
        dREN = 0;
        cyc(); cyc(); cyc();
        check("err_after_timeout", 32'(err), 1);
        check("busy_end", 32'(busy), 0);
        check("hq_empty", hq.size(), 0);
        check("aq_empty", aq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
